// File: rtl/stop_watch_disp_mux.sv
// Four-digit common-anode seven-segment scanner for the stopwatch core.
// Digits are snapshotted once per scan frame; anodes are blanked for a guard interval at each slot start.
module stop_watch_disp_mux #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 2,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  localparam int unsigned CNT_W = 18;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);
  localparam bit LZ_EN = (BLANK_LZ != 0);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       s3, s2, s1, s0;
  logic [3:0]       sdp;

  logic             last_cnt;
  logic [3:0]       val;
  logic             blank;
  logic [6:0]       pat;
  logic [3:0]       an_c;
  logic [7:0]       sseg_c;

  // Next-output decode from the current slot position and the frame snapshot
  always_comb begin
    last_cnt = (cnt == CNT_MAX);
    val      = s0;
    blank    = 1'b0;
    pat      = 7'h3F;

    unique case (idx)
      2'd0: val = s0;
      2'd1: val = s1;
      2'd2: val = s2;
      2'd3: val = s3;
      default: val = s0;
    endcase

    // Only the minutes and seconds-tens digits are candidates for blanking
    if (LZ_EN) begin
      blank = ((idx == 2'd3) && (s3 == 4'd0)) ||
              ((idx == 2'd2) && (s3 == 4'd0) && (s2 == 4'd0));
    end

    case (val)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h3F;
    endcase

    an_c   = (cnt < GUARD_CNT) ? 4'hF : ~(4'b0001 << idx);
    sseg_c = blank ? 8'hFF : {~sdp[idx], pat};
  end

  // Slot counter, digit index, shadows and registered pin drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      idx  <= '0;
      an   <= 4'hF;
      sseg <= 8'hFF;
      s3   <= d3;
      s2   <= d2;
      s1   <= d1;
      s0   <= d0;
      sdp  <= dp_in;
    end else begin
      an   <= an_c;
      sseg <= sseg_c;
      if (last_cnt) begin
        cnt <= '0;
        idx <= idx + 2'd1;
        // Frame boundary: take a coherent copy of all four digits
        if (idx == 2'd3) begin
          s3  <= d3;
          s2  <= d2;
          s1  <= d1;
          s0  <= d0;
          sdp <= dp_in;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stop_watch_disp_mux.sv
// Bench for stop_watch_disp_mux: vector table, hand sequences and random stimulus against a frame-level model.
module tb_stop_watch_disp_mux;

  localparam int unsigned RD = 8;
  localparam int unsigned GD = 2;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d3, d2, d1, d0, dp_in;
  logic [3:0] an, an_nb;
  logic [7:0] sseg, sseg_nb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stop_watch_disp_mux #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LZ(1)) dut (
    .clk(clk), .reset(reset), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .dp_in(dp_in), .an(an), .sseg(sseg)
  );

  stop_watch_disp_mux #(.REFRESH_DIV(RD), .GUARD(GD), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .reset(reset), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .dp_in(dp_in), .an(an_nb), .sseg(sseg_nb)
  );

  // Reference model: position within the frame since reset plus a snapshot copy
  int         n;
  logic [3:0] m_s [4];
  logic [3:0] m_dp;
  logic [3:0] e_an;
  logic [7:0] e_sseg, e_sseg_nb;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic void model_out(input int p, input bit lz,
                                    output logic [3:0] a, output logic [7:0] s);
    int slot = (p / RD) % 4;
    int c    = p % RD;
    bit bl   = lz && ((slot == 3 && m_s[3] == 4'd0) ||
                      (slot == 2 && m_s[3] == 4'd0 && m_s[2] == 4'd0));
    a = (c < GD) ? 4'hF : ~(4'b0001 << slot);
    s = bl ? 8'hFF : {~m_dp[slot], seg7(m_s[slot])};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model at the edge, then compare both builds against it
  task automatic step();
    logic [3:0] tmp;
    bit snap;
    @(posedge clk);
    snap = 1'b0;
    if (reset) begin
      e_an = 4'hF; e_sseg = 8'hFF; e_sseg_nb = 8'hFF;
      n = 0;
      snap = 1'b1;
    end else begin
      model_out(n, 1'b1, e_an, e_sseg);
      model_out(n, 1'b0, tmp, e_sseg_nb);
      snap = ((n % FRAME) == FRAME - 1);
      n++;
    end
    if (snap) begin
      m_s[3] = d3; m_s[2] = d2; m_s[1] = d1; m_s[0] = d0; m_dp = dp_in;
    end
    #1;
    chk("model_an",      8'(an),    8'(e_an));
    chk("model_sseg",    sseg,      e_sseg);
    chk("model_an_nb",   8'(an_nb), 8'(e_an));
    chk("model_sseg_nb", sseg_nb,   e_sseg_nb);
  endtask

  task automatic set_d(input logic [3:0] a3, input logic [3:0] a2,
                       input logic [3:0] a1, input logic [3:0] a0, input logic [3:0] dp);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0; dp_in = dp;
  endtask

  typedef struct {
    logic [3:0]      v3, v2, v1, v0, dp;
    logic [3:0][7:0] seg;
    logic [3:0][7:0] seg_nb;
  } vec_t;

  vec_t vecs [7];
  logic [3:0] an_hand [4];

  initial begin
    an_hand[0] = 4'hE; an_hand[1] = 4'hD; an_hand[2] = 4'hB; an_hand[3] = 4'h7;
    vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{4'h0, 4'h0, 4'h5, 4'h7, 4'b1010, {8'hFF, 8'hFF, 8'h12, 8'hF8}, {8'h40, 8'hC0, 8'h12, 8'hF8}};
    vecs[2] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, {8'hFF, 8'hFF, 8'hC0, 8'hC0}, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[3] = '{4'h0, 4'h9, 4'h8, 4'hC, 4'b0000, {8'hFF, 8'h90, 8'h80, 8'hBF}, {8'hC0, 8'h90, 8'h80, 8'hBF}};
    vecs[4] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'b1111, {8'hFF, 8'hFF, 8'h79, 8'h40}, {8'h40, 8'h40, 8'h79, 8'h40}};
    vecs[5] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'b0100, {8'hA4, 8'h40, 8'hC0, 8'hC0}, {8'hA4, 8'h40, 8'hC0, 8'hC0}};
    vecs[6] = '{4'h0, 4'hA, 4'hF, 4'h3, 4'b0000, {8'hFF, 8'hBF, 8'hBF, 8'hB0}, {8'hC0, 8'hBF, 8'hBF, 8'hB0}};

    n = 0;
    m_dp = '0;
    for (int k = 0; k < 4; k++) m_s[k] = '0;

    // Power-up reset with 1,2,3,4 and the documented start-of-scan sequence
    reset = 1'b1;
    set_d(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("reset_an", 8'(an), 8'h0F);
      chk("reset_sseg", sseg, 8'hFF);
    end
    reset = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if ((i % RD) < GD) chk("t1_guard_an", 8'(an), 8'h0F);
      else               chk("t1_an", 8'(an), 8'(an_hand[i / RD]));
      if (i == 2) chk("t1_first_digit", sseg, 8'h99);
    end

    // Table of digit patterns: reset-load each vector and scan one full frame
    foreach (vecs[v]) begin
      set_d(vecs[v].v3, vecs[v].v2, vecs[v].v1, vecs[v].v0, vecs[v].dp);
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
        step();
        if ((i % RD) == 4) begin
          chk("vec_an",      8'(an), 8'(an_hand[i / RD]));
          chk("vec_sseg",    sseg,    vecs[v].seg[i / RD]);
          chk("vec_sseg_nb", sseg_nb, vecs[v].seg_nb[i / RD]);
        end
      end
    end

    // Mid-frame input change must not show until the following frame
    set_d(4'h1, 4'h2, 4'h3, 4'h1, 4'b0000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (i == RD + 2) begin d0 = 4'h2; d3 = 4'h5; end
      step();
      if (i == 4)              chk("t4_old_d0", sseg, 8'hF9);
      if (i == 3 * RD + 4)     chk("t4_old_d3", sseg, 8'hF9);
      if (i == FRAME + 4)      chk("t4_new_d0", sseg, 8'hA4);
      if (i == FRAME + 3 * RD + 4) chk("t4_new_d3", sseg, 8'h92);
    end

    // Reset pulse in the idx=2 slot at cnt=5, then restart at digit 0
    set_d(4'h1, 4'h2, 4'h3, 4'h4, 4'b0000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2 * RD + 5; i++) step();
    chk("t6_pre_an", 8'(an), 8'h0B);
    reset = 1'b1;
    step();
    chk("t6_rst_an", 8'(an), 8'h0F);
    chk("t6_rst_sseg", sseg, 8'hFF);
    reset = 1'b0;
    step(); chk("t6_g0_an", 8'(an), 8'h0F);
    step(); chk("t6_g1_an", 8'(an), 8'h0F);
    step(); chk("t6_d0_an", 8'(an), 8'h0E);
    chk("t6_d0_sseg", sseg, 8'h99);

    // Random digits, decimal points and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        d3 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        d2 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        d1 = 4'($urandom_range(0, 15));
        d0 = 4'($urandom_range(0, 15));
        dp_in = 4'($urandom_range(0, 15));
      end
      reset = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stop_watch_disp_mux.md
# stop_watch_disp_mux

Time-multiplexed driver for a 4-digit common-anode seven-segment display, fed by the stopwatch core's BCD digit outputs `d3..d0`. It snapshots the four digits once per scan frame so a frame never mixes old and new digits. It scans one digit per refresh slot with an anti-ghosting guard interval and applies leading-zero blanking and per-digit decimal points. All outputs are registered and go directly to the board anode and segment pins.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles per digit slot, legal range 2..2^18. The slot counter is 18 bits.
- `GUARD`, default 2: cycles at the start of each slot with all anodes off. Must satisfy 0 ≤ GUARD < REFRESH_DIV.
- `BLANK_LZ`, default 1: when 1, leading-zero blanking is enabled on digits 3 and 2.

Ports:
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `d3, d2, d1, d0`  in  4 each: BCD digits. `d3` is minutes, `d2`/`d1` are seconds tens/units, `d0` is tenths.
- `dp_in`  in  4: decimal-point request per digit, bit i maps to digit i, 1 = lit.
- `an`  out  4: anode enables, active-low. Bit i drives digit i.
- `sseg`  out  8: segments, active-low, ordered {dp,g,f,e,d,c,b,a}.

## Operation
- Internal state:
  - `cnt`: slot counter, 0..REFRESH_DIV-1.
  - `idx`: 2-bit digit index.
  - Shadow registers `s3..s0` (4 bits each) and `sdp` (4 bits).
- `cnt` increments every cycle. At REFRESH_DIV-1 it wraps to 0 and `idx` advances 0→1→2→3→0.
- Frame snapshot: on the edge where `cnt`==REFRESH_DIV-1 and `idx`==3, the shadows load `d3..d0` and `dp_in`. No other event updates the shadows except reset.
- Selected digit value v = s[idx]. Blank condition:
  - Only when BLANK_LZ=1.
  - Digit 3 is blank if s3==0.
  - Digit 2 is blank if s3==0 and s2==0.
  - Digits 1 and 0 are never blanked.
- Segment pattern, bits [6:0]:
  - BCD values: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex).
  - Values 10–15 → 3F (segment g only, a dash).
  - Blank → 7F.
- sseg[7] = ~sdp[idx]. It is forced to 1 when the digit is blank.
- Anodes:
  - If `cnt` < GUARD, `an` = 1111.
  - Otherwise `an` = ~(1<<idx).
- `sseg` is driven with the pattern during guard cycles too. Only `an` is suppressed.

## Timing
- Reset, sampled on a rising edge with `reset`=1:
  - `cnt`=0, `idx`=0.
  - `an`=1111, `sseg`=FF.
  - Shadows load the current `d3..d0` and `dp_in` on every reset cycle.
- Outputs are registered from the current `cnt`, `idx` and shadows, so `an` and `sseg` lag internal state by exactly 1 cycle.
- After the first edge with `reset`=0:
  - `an` stays 1111 for GUARD edges.
  - On edge GUARD+1, `an` becomes 1110, showing `s0`.
  - With GUARD=0, `an` becomes 1110 on the first edge.
- Each digit is enabled for REFRESH_DIV−GUARD cycles per slot. Frame period is 4·REFRESH_DIV cycles.
- Input changes are visible no earlier than the first slot-0 of the next frame, and at most 4·REFRESH_DIV+1 cycles after the change.
- Reset asserted mid-slot: on the next edge, outputs are off and the counter and index are zeroed. There is no partial-frame carry-over.
- Simultaneous snapshot edge and reset: reset wins. The shadows still load inputs, which is the same data.

## Test plan
All scenarios use REFRESH_DIV=8, GUARD=2, BLANK_LZ=1.

1. Reset 3 cycles with d=1,2,3,4 (d3..d0), dp_in=0000, then release → `an`=1111 for 2 cycles, then 1110 with `sseg`=99 ("4") for 6 cycles, then 1111×2, then 1101 with `sseg`=B0 ("3"), 1011 with A4, 0111 with F9.
2. d=0,0,5,7, dp_in=1010 → digit 3 `sseg`=FF (blank, dp suppressed), digit 2 FF, digit 1 12 ("5." with dp lit), digit 0 F8.
3. d=0,0,0,0 → digits 3 and 2 blank (FF), digit 1 C0, digit 0 C0. Then set BLANK_LZ=0 in a second build → all four show C0.
4. Change d0 from 1 to 2 mid-frame, during the `idx`=1 slot → digit 0 still shows F9 until the frame wraps; the next slot-0 shows A4. Confirm no frame contains mixed digits.
5. d0=4'hC → digit 0 `sseg`=BF (dash).
6. Assert `reset` for 1 cycle during the `idx`=2 slot, at `cnt`=5 → next edge `an`=1111, `sseg`=FF. Scan restarts at digit 0 after 2 guard cycles.
